// File: rtl/mips_bus_pkg.sv
// rtl/mips_bus_pkg.sv - shared state, owner and byte-lane definitions for the CPU bus arbiter
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWNER_FETCH,
        OWNER_DATA
    } owner_t;

    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mips_arb_grant.sv
// rtl/mips_arb_grant.sv - picks fetch or data; ARB_ROUND_ROBIN_EN alternates on contention,
// otherwise data has fixed priority over fetch.
module mips_arb_grant (
    input  logic if_req,
    input  logic d_req,
    input  logic last_data,
    output logic grant,
    output logic pick_data
);

    always_comb begin
        grant     = if_req | d_req;
        pick_data = d_req;
`ifdef ARB_ROUND_ROBIN_EN
        // On contention the requester that lost the previous grant goes next.
        if (if_req && d_req) begin
            pick_data = ~last_data;
        end
`endif
    end

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_last_data;
    assign unused_last_data = last_data;
`endif

endmodule

// File: rtl/mips_bus_arbiter.sv
// rtl/mips_bus_arbiter.sv - shares one Avalon-MM master between fetch and load/store units.
// Define ARB_ROUND_ROBIN_EN for alternating grants on contention (default: data first).
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_ready,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_ready,
    output logic [DATA_W-1:0]     d_rdata,
    output logic [ADDR_W-1:0]     address,
    output logic                  write,
    output logic                  read,
    input  logic                  waitrequest,
    output logic [DATA_W-1:0]     writedata,
    output logic [DATA_W/8-1:0]   byteenable,
    input  logic [DATA_W-1:0]     readdata,
    output logic                  busy
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t state;
    owner_t     owner;
    logic       grant;
    logic       pick_data;
    logic       last_data;

    // Low address bits are always forced to a word boundary, so they are never read.
    logic [3:0] unused_addr_bits;
    assign unused_addr_bits = {if_addr[1:0], d_addr[1:0]};

    assign last_data = (owner == OWNER_DATA);

    mips_arb_grant u_grant (
        .if_req    (if_req),
        .d_req     (d_req),
        .last_data (last_data),
        .grant     (grant),
        .pick_data (pick_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWNER_DATA;
            read       <= 1'b0;
            write      <= 1'b0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            busy       <= 1'b0;
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        state <= BUS;
                        busy  <= 1'b1;
                        if (pick_data) begin
                            owner      <= OWNER_DATA;
                            address    <= {d_addr[ADDR_W-1:2], 2'b00};
                            byteenable <= d_be;
                            writedata  <= d_wdata;
                            write      <= d_we;
                            read       <= ~d_we;
                        end else begin
                            owner      <= OWNER_FETCH;
                            address    <= {if_addr[ADDR_W-1:2], 2'b00};
                            byteenable <= {(BE_W / 4){BE_WORD}};
                            write      <= 1'b0;
                            read       <= 1'b1;
                        end
                    end
                end
                BUS: begin
                    // Zero-latency slave: readdata is valid in the cycle waitrequest drops.
                    if (!waitrequest) begin
                        state <= DONE;
                        read  <= 1'b0;
                        write <= 1'b0;
                        if (owner == OWNER_DATA) begin
                            d_ready <= 1'b1;
                            if (read) begin
                                d_rdata <= readdata;
                            end
                        end else begin
                            if_ready <= 1'b1;
                            if (read) begin
                                if_rdata <= readdata;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    read  <= 1'b0;
                    write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb/tb_mips_bus_arbiter.sv - self-checking bench for mips_bus_arbiter with a transaction-level model
module tb_mips_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_if;
    logic [31:0] exp_d;

    always #5 clk = ~clk;

    mips_bus_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_ready    (if_ready),
        .if_rdata    (if_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_be        (d_be),
        .d_ready     (d_ready),
        .d_rdata     (d_rdata),
        .address     (address),
        .write       (write),
        .read        (read),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata),
        .busy        (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_if = '0;
        exp_d  = '0;
    endtask

    task automatic test_reset();
        if_req = 0; d_req = 0; d_we = 0; waitrequest = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; readdata = 0;
        reset = 1'b1;
        step();
        step();
        vectors++;
        if ({read, write, if_ready, d_ready, busy} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 00000", {read, write, if_ready, d_ready, busy});
        end
        vectors++;
        if ({address, writedata, if_rdata, d_rdata, byteenable} !== 132'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h expected 0", {address, writedata, if_rdata, d_rdata, byteenable});
        end
        reset = 1'b0;
        exp_if = '0;
        exp_d  = '0;
        step();
    endtask

    task automatic test_fetch_nowait();
        if_req = 1; if_addr = 32'hBFC00002; waitrequest = 0; readdata = 32'h24020005;
        step();
        vectors++;
        if ({read, write, address, byteenable, busy} !== {2'b10, 32'hBFC00000, 4'hF, 1'b1}) begin
            miscompares++;
            $display("FAIL fetch_bus: got %h expected %h", {read, write, address, byteenable, busy},
                     {2'b10, 32'hBFC00000, 4'hF, 1'b1});
        end
        step();
        if_req = 0;
        exp_if = 32'h24020005;
        vectors++;
        if ({if_ready, d_ready, read, write, if_rdata} !== {4'b1000, exp_if}) begin
            miscompares++;
            $display("FAIL fetch_done: got %h expected %h", {if_ready, d_ready, read, write, if_rdata},
                     {4'b1000, exp_if});
        end
        step();
        vectors++;
        if ({if_ready, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL fetch_idle: got %b expected 00", {if_ready, busy});
        end
    endtask

    task automatic test_store_waits();
        d_req = 1; d_we = 1; d_addr = 32'h1000; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
        waitrequest = 1; readdata = $urandom;
        step();
        for (int i = 0; i < 4; i++) begin
            waitrequest = (i < 3);
            vectors++;
            if ({write, read, address, writedata, byteenable, d_ready} !==
                {2'b10, 32'h1000, 32'hDEADBEEF, 4'h3, 1'b0}) begin
                miscompares++;
                $display("FAIL store_hold[%0d]: got %h expected %h", i,
                         {write, read, address, writedata, byteenable, d_ready},
                         {2'b10, 32'h1000, 32'hDEADBEEF, 4'h3, 1'b0});
            end
            d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom); d_we = 1'($urandom);
            step();
        end
        d_req = 0; d_we = 0;
        vectors++;
        if ({d_ready, if_ready, write, read, d_rdata} !== {4'b1000, exp_d}) begin
            miscompares++;
            $display("FAIL store_done: got %h expected %h", {d_ready, if_ready, write, read, d_rdata},
                     {4'b1000, exp_d});
        end
        step();
    endtask

    task automatic test_load();
        d_req = 1; d_we = 0; d_addr = 32'h2006; d_be = 4'h4; waitrequest = 0; readdata = 32'h00AB0000;
        step();
        vectors++;
        if ({read, write, address, byteenable} !== {2'b10, 32'h2004, 4'h4}) begin
            miscompares++;
            $display("FAIL load_bus: got %h expected %h", {read, write, address, byteenable},
                     {2'b10, 32'h2004, 4'h4});
        end
        step();
        d_req = 0;
        exp_d = 32'h00AB0000;
        vectors++;
        if ({d_ready, if_ready, d_rdata, if_rdata} !== {2'b10, exp_d, exp_if}) begin
            miscompares++;
            $display("FAIL load_done: got %h expected %h", {d_ready, if_ready, d_rdata, if_rdata},
                     {2'b10, exp_d, exp_if});
        end
        step();
    endtask

    task automatic test_contention();
        logic        first_data;
        logic [31:0] a_if, a_d, r1, r2, a_first, a_second;
`ifdef ARB_ROUND_ROBIN_EN
        first_data = 1'b0;
`else
        first_data = 1'b1;
`endif
        do_reset();
        a_if = $urandom; a_d = $urandom; r1 = $urandom; r2 = $urandom;
        a_first  = (first_data ? a_d : a_if) & ~32'h3;
        a_second = (first_data ? a_if : a_d) & ~32'h3;
        if_req = 1; if_addr = a_if; d_req = 1; d_we = 0; d_addr = a_d; d_be = 4'hF;
        waitrequest = 0; readdata = r1;
        step();
        vectors++;
        if ({read, write, address} !== {2'b10, a_first}) begin
            miscompares++;
            $display("FAIL contend_first_bus: got %h expected %h", {read, write, address}, {2'b10, a_first});
        end
        step();
        vectors++;
        if ({if_ready, d_ready} !== (first_data ? 2'b01 : 2'b10)) begin
            miscompares++;
            $display("FAIL contend_first_ready: got %b expected %b", {if_ready, d_ready},
                     (first_data ? 2'b01 : 2'b10));
        end
        if (first_data) begin d_req = 0; exp_d = r1; end
        else begin if_req = 0; exp_if = r1; end
        readdata = r2;
        step();
        vectors++;
        if ({read, write, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL contend_gap: got %b expected 000", {read, write, busy});
        end
        step();
        vectors++;
        if ({read, write, address} !== {2'b10, a_second}) begin
            miscompares++;
            $display("FAIL contend_second_bus: got %h expected %h", {read, write, address}, {2'b10, a_second});
        end
        step();
        if (first_data) exp_if = r2;
        else exp_d = r2;
        vectors++;
        if ({if_ready, d_ready, if_rdata, d_rdata} !== {(first_data ? 2'b10 : 2'b01), exp_if, exp_d}) begin
            miscompares++;
            $display("FAIL contend_second_done: got %h expected %h", {if_ready, d_ready, if_rdata, d_rdata},
                     {(first_data ? 2'b10 : 2'b01), exp_if, exp_d});
        end
        if_req = 0; d_req = 0;
        step();
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, r;
        if_req = 1; if_addr = 32'h0040_0010; waitrequest = 1;
        step();
        vectors++;
        if (read !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_strobe: got %b expected 1", read);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({read, write, busy, if_ready} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rstmid_async: got %b expected 0000", {read, write, busy, if_ready});
        end
        if_req = 0; waitrequest = 0;
        exp_if = '0; exp_d = '0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if ({if_ready, d_ready, busy} !== 3'b000) begin
                miscompares++;
                $display("FAIL rstmid_quiet[%0d]: got %b expected 000", i, {if_ready, d_ready, busy});
            end
        end
        a = $urandom; r = $urandom;
        if_req = 1; if_addr = a; readdata = r;
        step();
        vectors++;
        if ({read, address} !== {1'b1, a & ~32'h3}) begin
            miscompares++;
            $display("FAIL rstmid_refetch_bus: got %h expected %h", {read, address}, {1'b1, a & ~32'h3});
        end
        step();
        if_req = 0;
        exp_if = r;
        vectors++;
        if ({if_ready, if_rdata} !== {1'b1, exp_if}) begin
            miscompares++;
            $display("FAIL rstmid_refetch_done: got %h expected %h", {if_ready, if_rdata}, {1'b1, exp_if});
        end
        step();
    endtask

    task automatic test_back_to_back();
        int pulses[$];
        logic [31:0] r;
        r = $urandom;
        if_req = 1; if_addr = $urandom; waitrequest = 0; readdata = r;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (if_ready === 1'b1) pulses.push_back(c);
            if (c == 8) if_req = 0;
        end
        step();
        exp_if = r;
        vectors++;
        if (pulses.size() != 3 || pulses[0] != 2 || pulses[1] - pulses[0] != 3 || pulses[2] - pulses[1] != 3) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d pulses first at %0d expected 3 pulses at 2,5,8",
                     pulses.size(), (pulses.size() > 0) ? pulses[0] : -1);
        end
        vectors++;
        if ({busy, if_rdata} !== {1'b0, exp_if}) begin
            miscompares++;
            $display("FAIL b2b_end: got %h expected %h", {busy, if_rdata}, {1'b0, exp_if});
        end
    endtask

    task automatic test_random();
        int          kind, waits;
        logic [31:0] a, wd, rd, ea;
        logic [3:0]  be, ebe;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            waits = $urandom_range(0, 3);
            a = $urandom; wd = $urandom; rd = $urandom; be = 4'($urandom_range(1, 15));
            ea  = a & ~32'h3;
            ebe = (kind == 0) ? 4'hF : be;
            readdata = rd;
            if (kind == 0) begin
                if_req = 1; if_addr = a;
            end else begin
                d_req = 1; d_we = (kind == 2); d_addr = a; d_wdata = wd; d_be = be;
            end
            step();
            for (int i = 0; i <= waits; i++) begin
                waitrequest = (i < waits);
                vectors++;
                if ({read, write, address, byteenable, if_ready, d_ready, busy} !==
                    {(kind != 2), (kind == 2), ea, ebe, 3'b001}) begin
                    miscompares++;
                    $display("FAIL rand_bus[%0d.%0d]: got %h expected %h", n, i,
                             {read, write, address, byteenable, if_ready, d_ready, busy},
                             {(kind != 2), (kind == 2), ea, ebe, 3'b001});
                end
                if (kind == 2) begin
                    vectors++;
                    if (writedata !== wd) begin
                        miscompares++;
                        $display("FAIL rand_wdata[%0d]: got %h expected %h", n, writedata, wd);
                    end
                end
                if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
                if (kind != 0) d_we = 1'($urandom);
                step();
            end
            if (kind == 0) exp_if = rd;
            if (kind == 1) exp_d = rd;
            if_req = 0; d_req = 0; waitrequest = 0;
            vectors++;
            if ({if_ready, d_ready, read, write, if_rdata, d_rdata} !==
                {(kind == 0), (kind != 0), 2'b00, exp_if, exp_d}) begin
                miscompares++;
                $display("FAIL rand_done[%0d]: got %h expected %h", n,
                         {if_ready, d_ready, read, write, if_rdata, d_rdata},
                         {(kind == 0), (kind != 0), 2'b00, exp_if, exp_d});
            end
            step();
            vectors++;
            if ({if_ready, d_ready, busy} !== 3'b000) begin
                miscompares++;
                $display("FAIL rand_idle[%0d]: got %b expected 000", n, {if_ready, d_ready, busy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_nowait();
        test_store_waits();
        test_load();
        test_contention();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Shares the CPU's single Avalon memory-mapped master port between two internal requesters: the instruction-fetch unit and the load/store (data) unit.
- Sequences each transfer through the Avalon read/write/waitrequest handshake and returns registered read data.
- Pulses a per-requester ready signal when a transfer completes.
- Sits between the CPU control FSM and the top-level bus pins.

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width; byteenable width is DATA_W/8.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; level, held until if_ready.
- if_addr  in  ADDR_W  fetch byte address.
- if_ready  out  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; level, held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data, already lane-aligned.
- d_be  in  DATA_W/8  store/load byte lanes.
- d_ready  out  1  one-cycle pulse: data transfer complete.
- d_rdata  out  DATA_W  load word (full word; the requester extracts lanes).
- address  out  ADDR_W  Avalon address.
- write  out  1  Avalon write strobe.
- read  out  1  Avalon read strobe.
- waitrequest  in  1  Avalon stall.
- writedata  out  DATA_W  Avalon write data.
- byteenable  out  DATA_W/8  Avalon byte enables.
- readdata  in  DATA_W  Avalon read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, BUS, DONE.
- All outputs are registered. Reset (asynchronous, immediate):
  - state = IDLE.
  - read, write, if_ready, d_ready, busy = 0.
  - address, writedata, if_rdata, d_rdata = 0.
  - byteenable = 0.
  - Grant owner = data.
- IDLE:
  - Requests are sampled only in IDLE.
  - If d_req, grant data. Else if if_req, grant fetch. Else stay in IDLE.
  - On grant, register address = {addr[ADDR_W-1:2], 2'b00}; low bits are forced to 0.
  - Fetch grant: byteenable = all ones, read = 1.
  - Data grant: byteenable = d_be; write = d_we, read = ~d_we; writedata = d_wdata.
  - Go to BUS.
- BUS:
  - Hold address, byteenable, writedata and the strobe stable while waitrequest = 1. There is no timeout.
  - The transfer completes in the first BUS cycle with waitrequest = 0.
  - On a read completion, capture readdata into if_rdata or d_rdata (by owner) in that same cycle; Avalon read latency is 0.
  - On completion, deassert read/write and go to DONE.
- DONE:
  - Pulse the owner's ready for exactly one cycle, then go to IDLE.
  - The requester must drop req in the DONE cycle. Any req still high in the following IDLE cycle is a new request.
- Minimum latency: request seen in IDLE at cycle 0 → strobe at cycle 1 → ready at cycle 2. Each wait cycle adds 1.
- if_rdata and d_rdata hold their last value until overwritten by the next read for that owner. Stores leave d_rdata unchanged.
- read and write are never high together. No strobe is asserted outside BUS.
- Simultaneous requests: exactly one is granted; the loser stays pending and is served in the next IDLE.
- A request arriving during BUS or DONE waits for IDLE.
- Reset mid-BUS: strobes drop immediately, the transfer is abandoned, and no ready pulse is issued.
- Changing d_addr, d_wdata, d_be or d_we while a transfer is in progress has no effect; they are captured in IDLE.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both requests are present in IDLE, grant the requester that did not win the last grant; a single request is always granted. The last-grant flag resets to "data", so the first contended grant goes to fetch.
- Undefined: fixed priority, data over fetch.

Decomposition:
- Package mips_bus_pkg contains:
  - arb_state_t enum {IDLE, BUS, DONE}.
  - owner_t enum {OWNER_FETCH, OWNER_DATA}.
  - Constant BE_WORD = 4'b1111.
- One combinational sub-module, mips_arb_grant, computes the winner from if_req, d_req and the last owner, including the ARB_ROUND_ROBIN_EN variant.

Test Plan:
- Fetch, no wait: if_req = 1, if_addr = 0xBFC00002, waitrequest = 0, readdata = 0x24020005 → read = 1 with address 0xBFC00000 and byteenable = 0xF at cycle 1; if_ready pulse with if_rdata = 0x24020005 at cycle 2.
- Store with waits: d_req = 1, d_we = 1, d_addr = 0x1000, d_wdata = 0xDEADBEEF, d_be = 0x3, waitrequest = 1 for 3 cycles → write held with address, data and byteenable stable for 3 cycles, completes on the 4th BUS cycle, d_ready the cycle after; d_rdata unchanged.
- Contention: if_req = 1 and d_req = 1 asserted in the same cycle:
  - Fixed priority → data is served first, then fetch, with no overlapping strobes.
  - With ARB_ROUND_ROBIN_EN, from reset → fetch first, then data.
- Reset mid-transfer: assert reset while read = 1 and waitrequest = 1 → read = 0 immediately, busy = 0, no ready pulse; a fresh if_req after reset is served normally.
- Back-to-back: hold if_req high across if_ready → a second fetch starts in the cycle after IDLE; the ready pulses are 3 cycles apart with waitrequest = 0.
- Load: d_we = 0, d_be = 0x4, readdata = 0x00AB0000 → read = 1, byteenable = 0x4, d_rdata = 0x00AB0000; if_rdata unchanged.
